// File: rtl/dsi_frame_sequencer.sv
// Command sequencer feeding DPHY_TX_BYTE: one LCD init command, then one write command per line.
// Optional build macro TEST_PATTERN_EN adds test_pattern_i and the test-pattern line codes.
module dsi_frame_sequencer #(
    parameter int unsigned LINES          = 240,
    parameter logic [7:0]  CMD_INIT       = 8'h89,
    parameter logic [7:0]  CMD_LINE_FIRST = 8'h3F,
    parameter logic [7:0]  CMD_LINE_NEXT  = 8'h6B,
    parameter logic [7:0]  CMD_TP_FIRST   = 8'hCF,
    parameter logic [7:0]  CMD_TP_NEXT    = 8'hD9,
    parameter int unsigned WR_PULSE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clock_slow_sync_i,
    input  logic       reset_i,
    input  logic       start_frame_i,
    input  logic       line_ready_i,
    input  logic       tx_finish_i,
`ifdef TEST_PATTERN_EN
    input  logic       test_pattern_i,
`endif
    output logic [7:0] command_o,
    output logic       write_cmd_o,
    output logic       busy_o,
    output logic       init_done_o,
    output logic [7:0] line_index_o,
    output logic       frame_done_o,
    output logic       timeout_err_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_t;

    localparam logic [7:0]  LAST_LINE  = 8'(LINES - 1);
    localparam logic [3:0]  PULSE_LAST = 4'(WR_PULSE);
    localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [3:0]  pulse_cnt;
    logic [19:0] tmo_cnt;
    logic        is_init;   // command in flight is the init command
    logic        tp_mode;   // test-pattern frame, latched at frame start
    logic        tp_in;
    logic        tmo_hit;
    logic        can_issue;

`ifdef TEST_PATTERN_EN
    assign tp_in = test_pattern_i;
`else
    assign tp_in = 1'b0;
`endif

    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign can_issue = is_init || tp_mode || line_ready_i;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below reads the values from before this edge.
    always_ff @(posedge clock_slow_sync_i) begin
        if (reset_i) begin
            state         <= IDLE;
            pulse_cnt     <= '0;
            tmo_cnt       <= '0;
            is_init       <= 1'b0;
            tp_mode       <= 1'b0;
            command_o     <= 8'h00;
            write_cmd_o   <= 1'b0;
            busy_o        <= 1'b0;
            init_done_o   <= 1'b0;
            line_index_o  <= 8'd0;
            frame_done_o  <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            frame_done_o  <= 1'b0;
            timeout_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame_i) begin
                        state        <= ISSUE;
                        busy_o       <= 1'b1;
                        line_index_o <= 8'd0;
                        tp_mode      <= tp_in;
                        is_init      <= !init_done_o;
                        if (!init_done_o)
                            command_o <= CMD_INIT;
                        else
                            command_o <= tp_in ? CMD_TP_FIRST : CMD_LINE_FIRST;
                    end
                end
                ISSUE: begin
                    if (!write_cmd_o) begin
                        if (can_issue) begin
                            write_cmd_o <= 1'b1;
                            pulse_cnt   <= 4'd1;
                            tmo_cnt     <= '0;
                        end
                    end else if (tmo_hit) begin
                        state         <= IDLE;
                        write_cmd_o   <= 1'b0;
                        busy_o        <= 1'b0;
                        init_done_o   <= 1'b0;
                        line_index_o  <= 8'd0;
                        timeout_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                        if (pulse_cnt == PULSE_LAST) begin
                            write_cmd_o <= 1'b0;
                            state       <= WAIT_ACK;
                        end else begin
                            pulse_cnt <= pulse_cnt + 4'd1;
                        end
                    end
                end
                WAIT_ACK, WAIT_DONE: begin
                    if (tmo_hit) begin
                        state         <= IDLE;
                        busy_o        <= 1'b0;
                        init_done_o   <= 1'b0;
                        line_index_o  <= 8'd0;
                        timeout_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                        if (state == WAIT_ACK && !tx_finish_i)
                            state <= WAIT_DONE;
                        else if (state == WAIT_DONE && tx_finish_i)
                            state <= NEXT;
                    end
                end
                NEXT: begin
                    if (is_init) begin
                        is_init     <= 1'b0;
                        init_done_o <= 1'b1;
                        command_o   <= tp_mode ? CMD_TP_FIRST : CMD_LINE_FIRST;
                        state       <= ISSUE;
                    end else if (line_index_o < LAST_LINE) begin
                        line_index_o <= line_index_o + 8'd1;
                        command_o    <= tp_mode ? CMD_TP_NEXT : CMD_LINE_NEXT;
                        state        <= ISSUE;
                    end else begin
                        frame_done_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_frame_sequencer.sv
// Scoreboard bench for dsi_frame_sequencer (LINES=4, TIMEOUT_CYCLES=50) with a behavioural TX model.
// Define TEST_PATTERN_EN for both files to exercise the test-pattern frame.
module tb_dsi_frame_sequencer;

    localparam int LINES   = 4;
    localparam int TMO     = 50;
    localparam int BUDGET  = 2000;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_frame = 1'b0;
    logic       line_ready = 1'b1;
    logic       tx_finish;
    logic       test_pattern = 1'b0;
    logic [7:0] command;
    logic       write_cmd;
    logic       busy;
    logic       init_done;
    logic [7:0] line_index;
    logic       frame_done;
    logic       timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_frames = 0;
    int   cyc      = 0;
    int   last_rise_cyc = 0;
    logic prev_write = 1'b0;
    logic tx_stuck = 1'b0;
    logic tx_seen  = 1'b0;
    exp_t sb[$];

    dsi_frame_sequencer #(
        .LINES(LINES),
        .WR_PULSE(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_slow_sync_i(clk),
        .reset_i(reset),
        .start_frame_i(start_frame),
        .line_ready_i(line_ready),
        .tx_finish_i(tx_finish),
`ifdef TEST_PATTERN_EN
        .test_pattern_i(test_pattern),
`endif
        .command_o(command),
        .write_cmd_o(write_cmd),
        .busy_o(busy),
        .init_done_o(init_done),
        .line_index_o(line_index),
        .frame_done_o(frame_done),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX model: finish drops 3 cycles after a strobe and rises 20 cycles later.
    initial begin
        tx_finish = 1'b1;
        forever begin
            @(negedge clk);
            if (write_cmd && !tx_seen) begin
                tx_seen = 1'b1;
                repeat (3) @(negedge clk);
                if (!tx_stuck) tx_finish = 1'b0;
                repeat (20) @(negedge clk);
                tx_finish = 1'b1;
            end
            if (!write_cmd) tx_seen = 1'b0;
        end
    end

    // Monitor: every rising strobe pops one expected command/line pair.
    always @(negedge clk) begin
        if (frame_done) n_frames <= n_frames + 1;
        if (write_cmd && !prev_write) begin
            last_rise_cyc <= cyc;
            if (sb.size() == 0) begin
                check("unexpected_strobe", {24'h0, command}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_cmd", {24'h0, command}, {24'h0, e.cmd});
                check("strobe_line", {24'h0, line_index}, {24'h0, e.idx});
            end
        end
        prev_write <= write_cmd;
    end

    task automatic push(input logic [7:0] cmd, input logic [7:0] idx);
        exp_t e;
        e.cmd = cmd;
        e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic push_lines(input logic [7:0] first, input logic [7:0] next);
        push(first, 8'd0);
        for (int i = 1; i < LINES; i++) push(next, 8'(i));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check(name, {31'h0, seen}, 32'd1);
        @(negedge clk);
        check({name, "_pulse_width"}, {31'h0, frame_done}, 32'd0);
        check({name, "_idle"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        bit ok;
        bit seen;

        // Test 1: reset values, then first frame with init.
        repeat (3) @(negedge clk);
        check("rst_command", {24'h0, command}, 32'h00);
        check("rst_write", {31'h0, write_cmd}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_init_done", {31'h0, init_done}, 32'd0);
        check("rst_line_index", {24'h0, line_index}, 32'd0);
        check("rst_frame_done", {31'h0, frame_done}, 32'd0);
        check("rst_timeout", {31'h0, timeout_err}, 32'd0);
        reset = 1'b0;
        push(8'h89, 8'd0);
        push_lines(8'h3F, 8'h6B);
        pulse_start();
        wait_frame("t1_frame_done");
        check("t1_init_done", {31'h0, init_done}, 32'd1);
        check("t1_frame_count", n_frames, 32'd1);

        // Test 2: second frame skips init; start-to-strobe latency; mid-frame start ignored.
        repeat (5) @(negedge clk);
        push_lines(8'h3F, 8'h6B);
        @(negedge clk);
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        check("t2_no_strobe_yet", {31'h0, write_cmd}, 32'd0);
        @(negedge clk);
        check("t2_latency", {31'h0, write_cmd}, 32'd1);
        repeat (30) @(negedge clk);
        pulse_start();
        wait_frame("t2_frame_done");
        check("t2_frame_count", n_frames, 32'd2);

        // Test 3: line_ready low for 100 cycles gates the line 2 strobe.
        repeat (5) @(negedge clk);
        push_lines(8'h3F, 8'h6B);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (line_index == 8'd1 && write_cmd) seen = 1'b1;
        end
        check("t3_reach_line1", {31'h0, seen}, 32'd1);
        line_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (line_index == 8'd2) seen = 1'b1;
        end
        check("t3_reach_line2", {31'h0, seen}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (write_cmd !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check("t3_gate_hold", {31'h0, ok}, 32'd1);
        line_ready = 1'b1;
        @(negedge clk);
        check("t3_strobe_after_ready", {31'h0, write_cmd}, 32'd1);
        wait_frame("t3_frame_done");

        // Test 4: TX never accepts; abort exactly TMO cycles after the strobe.
        repeat (5) @(negedge clk);
        tx_stuck = 1'b1;
        push(8'h3F, 8'd0);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
        end
        check("t4_timeout_seen", {31'h0, seen}, 32'd1);
        check("t4_timeout_delay", cyc - last_rise_cyc, TMO);
        check("t4_idle", {31'h0, busy}, 32'd0);
        check("t4_init_cleared", {31'h0, init_done}, 32'd0);
        @(negedge clk);
        check("t4_pulse_width", {31'h0, timeout_err}, 32'd0);
        tx_stuck = 1'b0;
        repeat (30) @(negedge clk);

`ifdef TEST_PATTERN_EN
        // Test 6: test-pattern frame ignores line_ready and uses the TP codes.
        test_pattern = 1'b1;
        line_ready = 1'b0;
        push(8'h89, 8'd0);
        push_lines(8'hCF, 8'hD9);
        pulse_start();
        test_pattern = 1'b0;
        wait_frame("t6_frame_done");
        line_ready = 1'b1;
        repeat (5) @(negedge clk);
        push(8'h3F, 8'd0);
`else
        push(8'h89, 8'd0);
`endif

        // Test 5: reset during a strobe, then a full frame re-sends init.
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (write_cmd) seen = 1'b1;
        end
        check("t5_strobe_seen", {31'h0, seen}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_write", {31'h0, write_cmd}, 32'd0);
        check("t5_rst_command", {24'h0, command}, 32'h00);
        check("t5_rst_busy", {31'h0, busy}, 32'd0);
        check("t5_rst_init_done", {31'h0, init_done}, 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        push(8'h89, 8'd0);
        push_lines(8'h3F, 8'h6B);
        pulse_start();
        wait_frame("t5_frame_done");

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
